// File: rtl/atm_ledger_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// atm_pkg : shared types and requester mapping for the ATM ledger arbiter
// Revision: 1.0
// ============================================================================
package atm_pkg;

   typedef enum logic {
      OP_DEBIT  = 1'b0,
      OP_CREDIT = 1'b1
   } op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      COMMIT = 2'd2,
      RESP   = 2'd3
   } ledger_state_t;

   localparam int REQ_WITHDRAW = 0;
   localparam int REQ_DEPOSIT  = 1;
   localparam int REQ_TRANSFER = 2;

   // Only the deposit port credits; withdraw and transfer both debit.
   function automatic op_t REQ_OP(input int idx);
      return (idx == REQ_DEPOSIT) ? OP_CREDIT : OP_DEBIT;
   endfunction

endpackage
`default_nettype wire

// File: rtl/atm_ledger_arbiter_if.sv
`default_nettype none
// ============================================================================
// atm_ledger_arbiter_if : requester/ledger bundle between menu FSM and ledger
// Revision: 1.0
// ============================================================================
interface atm_ledger_arbiter_if #(
   parameter int NREQ  = 3,
   parameter int AMT_W = 32
) ();

   logic [NREQ-1:0]       req;
   logic [NREQ*AMT_W-1:0] amount;
   logic [NREQ-1:0]       gnt;
   logic                  done;
   logic                  ok;
   logic                  err_insufficient;
   logic                  err_overflow;
   logic [AMT_W-1:0]      balance;
   logic                  busy;

   modport master (
      output req, amount,
      input  gnt, done, ok, err_insufficient, err_overflow, balance, busy
   );

   modport slave (
      input  req, amount,
      output gnt, done, ok, err_insufficient, err_overflow, balance, busy
   );

endinterface
`default_nettype wire

// File: rtl/atm_ledger_arbiter_rr.sv
`default_nettype none
// ============================================================================
// atm_rr_arbiter : round-robin winner select with a rotating priority pointer
// Revision: 1.0
// ============================================================================
module atm_rr_arbiter #(
   parameter  int NREQ  = 3,
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic [NREQ-1:0]  req_i,
   input  wire logic             adv_i,
   input  wire logic [IDX_W-1:0] win_idx_i,
   output logic      [NREQ-1:0]  win_oh_o,
   output logic                  any_req_o
);

   logic [IDX_W-1:0] ptr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (adv_i) begin
         ptr_q <= (win_idx_i == IDX_W'(NREQ - 1)) ? '0 : win_idx_i + IDX_W'(1);
      end
   end

   // Scan from the pointer upward, wrapping, and take the first active request.
   always_comb begin
      int  idx;
      logic found;
      win_oh_o = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_i[idx]) begin
            win_oh_o[idx] = 1'b1;
            found         = 1'b1;
         end
      end
   end

   assign any_req_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/atm_ledger_arbiter.sv
`default_nettype none
// ============================================================================
// atm_ledger_arbiter : sole writer of the account balance; runs one
//                      check-and-commit transaction per round-robin grant
// Revision: 1.0
// ============================================================================
module atm_ledger_arbiter
   import atm_pkg::*;
#(
   parameter int               NREQ         = 3,
   parameter int               AMT_W        = 32,
   parameter logic [AMT_W-1:0] INIT_BALANCE = 32'd100000
) (
   input wire logic      clk,
   input wire logic      reset,
   atm_ledger_arbiter_if.slave bus
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   ledger_state_t    state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [AMT_W-1:0] amt_q, amt_d;
   op_t              op_q, op_d;
   logic             ok_q, ok_d;
   logic [AMT_W-1:0] bal_q, bal_d;
   logic             done_q, done_d;
   logic             rsp_ok_q, rsp_ok_d;
   logic             err_ins_q, err_ins_d;
   logic             err_ovf_q, err_ovf_d;
   logic             busy_q, busy_d;

   logic [NREQ-1:0]  win_oh;
   logic             any_req;
   logic             adv;
   logic [IDX_W-1:0] win_idx;
   logic [AMT_W:0]   sum;

   atm_rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .req_i     (bus.req),
      .adv_i     (adv),
      .win_idx_i (win_idx),
      .win_oh_o  (win_oh),
      .any_req_o (any_req)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) win_idx = IDX_W'(i);
      end
   end

   // One extra bit so a credit overflow shows up as a carry instead of a wrap.
   assign sum = {1'b0, bal_q} + {1'b0, amt_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         amt_q     <= '0;
         op_q      <= OP_DEBIT;
         ok_q      <= 1'b0;
         bal_q     <= INIT_BALANCE;
         done_q    <= 1'b0;
         rsp_ok_q  <= 1'b0;
         err_ins_q <= 1'b0;
         err_ovf_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         amt_q     <= amt_d;
         op_q      <= op_d;
         ok_q      <= ok_d;
         bal_q     <= bal_d;
         done_q    <= done_d;
         rsp_ok_q  <= rsp_ok_d;
         err_ins_q <= err_ins_d;
         err_ovf_q <= err_ovf_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      amt_d     = amt_q;
      op_d      = op_q;
      ok_d      = ok_q;
      bal_d     = bal_q;
      done_d    = 1'b0;
      rsp_ok_d  = 1'b0;
      err_ins_d = 1'b0;
      err_ovf_d = 1'b0;
      adv       = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = CHECK;
               gnt_d   = win_oh;
               amt_d   = bus.amount[int'(win_idx)*AMT_W +: AMT_W];
               op_d    = REQ_OP(int'(win_idx));
               adv     = 1'b1;
            end
         end
         CHECK: begin
            ok_d    = (op_q == OP_DEBIT) ? (amt_q <= bal_q) : !sum[AMT_W];
            state_d = COMMIT;
         end
         COMMIT: begin
            if (ok_q) begin
               bal_d = (op_q == OP_DEBIT) ? (bal_q - amt_q) : sum[AMT_W-1:0];
            end
            // Status is registered here so it appears exactly in the RESP cycle.
            done_d    = 1'b1;
            rsp_ok_d  = ok_q;
            err_ins_d = !ok_q && (op_q == OP_DEBIT);
            err_ovf_d = !ok_q && (op_q == OP_CREDIT);
            state_d   = RESP;
         end
         RESP: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign bus.gnt              = gnt_q;
   assign bus.done             = done_q;
   assign bus.ok               = rsp_ok_q;
   assign bus.err_insufficient = err_ins_q;
   assign bus.err_overflow     = err_ovf_q;
   assign bus.balance          = bal_q;
   assign bus.busy             = busy_q;

endmodule
`default_nettype wire
